pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter D, default 10, the program-counter width in bits, matching the branch-target LUT output width.
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port Start, input, 1, a request to begin execution at address 0.
REQ-005 The block SHALL have port Stall, input, 1, which freezes all sequencer state for the cycle.
REQ-006 The block SHALL have port Halt, input, 1, asserted when the decoded instruction is a halt.
REQ-007 The block SHALL have port Jump, input, 1, a taken absolute branch to Target.
REQ-008 The block SHALL have port Call, input, 1, a taken call: jump to Target and push the return address.
REQ-009 The block SHALL have port Ret, input, 1, a return: pop the return address into the PC.
REQ-010 The block SHALL have port Target, input, D, the absolute branch target from the branch-target LUT.
REQ-011 The block SHALL have port Prog_ctr, output, D, the registered current instruction address.
REQ-012 The block SHALL have port Fetch_en, output, 1, high when Prog_ctr holds a valid fetch address (state RUN).
REQ-013 The block SHALL have port Done, output, 1, high in state DONE.
REQ-014 The block SHALL have port Stack_err, output, 1, a sticky flag for return-stack overflow or underflow.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE; Fetch_en = (state==RUN) and Done = (state==DONE), both decoded from state with no extra latency.
REQ-016 The block SHALL, in IDLE with Start=1, set Prog_ctr to 0 and enter RUN on the next edge; all other inputs are ignored in IDLE.
REQ-017 The block SHALL, in RUN with Stall=1, hold Prog_ctr, state and stack unchanged, ignoring Halt, Jump, Call and Ret.
REQ-018 The block SHALL, in RUN with Stall=0, apply exactly one action per edge with priority Halt > Ret > Call > Jump > increment.
REQ-019 On Halt the block SHALL hold Prog_ctr and enter DONE.
REQ-020 On Jump the block SHALL load Prog_ctr <= Target.
REQ-021 On increment the block SHALL load Prog_ctr <= Prog_ctr+1 modulo 2**D, so 2**D-1 wraps to 0 with no flag.
REQ-022 The block SHALL, in DONE with Start=1, set Prog_ctr to 0 and re-enter RUN while keeping stack contents and Stack_err; without Start it holds.
REQ-023 The block SHALL ignore Start while in RUN.
REQ-024 Every action's effect SHALL be visible on Prog_ctr one cycle after the sampling edge; there is no combinational path from inputs to outputs.

Reset
REQ-025 The block SHALL, on Reset_n=0 at any time including mid-RUN, immediately set state to IDLE, Prog_ctr to 0, stack pointer to 0 and Stack_err to 0.
REQ-026 The block SHALL make Fetch_en=0 and Done=0 follow from state IDLE during reset.
REQ-027 The block SHALL resume normal operation on the first rising Clk after Reset_n deasserts.

Configuration
REQ-028 The block SHALL provide macro PC_RETSTACK_EN, which enables a 4-entry return-address stack of D-bit entries.
REQ-029 With PC_RETSTACK_EN defined, Call SHALL push Prog_ctr+1 (mod 2**D) and load Target.
REQ-030 With PC_RETSTACK_EN defined, a Call with the stack full SHALL load Target, not push, and set Stack_err.
REQ-031 With PC_RETSTACK_EN defined, Ret SHALL pop the top entry into Prog_ctr.
REQ-032 With PC_RETSTACK_EN defined, a Ret with the stack empty SHALL increment Prog_ctr and set Stack_err.
REQ-033 Without PC_RETSTACK_EN, Call SHALL behave exactly as Jump, Ret SHALL behave as increment, Stack_err SHALL be tied 0, and no stack storage is synthesized.

Verification
REQ-034 The bench SHALL check: reset, then Start pulse, then 3 free cycles -> Prog_ctr 0,1,2,3 with Fetch_en=1 and Done=0.
REQ-035 The bench SHALL check: Prog_ctr=5, Jump=1, Target=81 -> Prog_ctr=81 next cycle; with Stall=1 also asserted -> Prog_ctr stays 5.
REQ-036 The bench SHALL check: D=10, Prog_ctr=1023 with no control input -> Prog_ctr=0 and Stack_err=0.
REQ-037 The bench SHALL check, with PC_RETSTACK_EN: at 10, Call with Target=44 -> 44; then Ret -> 11; five nested Calls -> Stack_err=1 after the fifth.
REQ-038 The bench SHALL check: Halt at Prog_ctr=120 -> Done=1 with Prog_ctr held at 120; then Start -> Prog_ctr=0 and RUN.
REQ-039 The bench SHALL check: Reset_n pulled low mid-RUN between clock edges -> Prog_ctr=0, Fetch_en=0 and Stack_err=0 immediately, before the next edge.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer (IDLE/RUN/DONE) with jump/call/return.
//            Define PC_RETSTACK_EN for a 4-entry return-address stack.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int D = 10
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Stall,
    input  logic         Halt,
    input  logic         Jump,
    input  logic         Call,
    input  logic         Ret,
    input  logic [D-1:0] Target,
    output logic [D-1:0] Prog_ctr,
    output logic         Fetch_en,
    output logic         Done,
    output logic         Stack_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [D-1:0]   r_pc;
    logic [D-1:0]   w_pc_nxt;
    logic [D-1:0]   w_pc_inc;

    assign w_pc_inc = r_pc + {{(D-1){1'b0}}, 1'b1};

`ifdef PC_RETSTACK_EN
    localparam int unsigned c_DEPTH = 4;

    logic [D-1:0]   r_stack [c_DEPTH];
    logic [2:0]     r_sp;
    logic           r_stack_err;
    logic           w_push;
    logic           w_pop;
    logic           w_err_set;
    logic [1:0]     w_top_idx;

    assign w_top_idx = r_sp[1:0] - 2'd1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
`ifdef PC_RETSTACK_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    if (Halt) begin
                        w_state_nxt = ST_DONE;
                    end else if (Ret) begin
`ifdef PC_RETSTACK_EN
                        // Underflow falls through to a plain increment.
                        if (r_sp != 3'd0) begin
                            w_pc_nxt = r_stack[w_top_idx];
                            w_pop    = 1'b1;
                        end else begin
                            w_pc_nxt  = w_pc_inc;
                            w_err_set = 1'b1;
                        end
`else
                        w_pc_nxt = w_pc_inc;
`endif
                    end else if (Call) begin
                        w_pc_nxt = Target;
`ifdef PC_RETSTACK_EN
                        if (r_sp != 3'(c_DEPTH)) begin
                            w_push = 1'b1;
                        end else begin
                            w_err_set = 1'b1;
                        end
`endif
                    end else if (Jump) begin
                        w_pc_nxt = Target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

`ifdef PC_RETSTACK_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sp        <= 3'd0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + 3'd1;
            end else if (w_pop) begin
                r_sp <= r_sp - 3'd1;
            end
            if (w_err_set) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    // Entries need no reset: they are only read below a valid stack pointer.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_stack[r_sp[1:0]] <= w_pc_inc;
        end
    end

    assign Stack_err = r_stack_err;
`else
    assign Stack_err = 1'b0;
`endif

    assign Prog_ctr = r_pc;
    assign Fetch_en = (r_state == ST_RUN);
    assign Done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (D = 10).
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam int D = 10;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Start, Stall, Halt, Jump, Call, Ret;
    logic [D-1:0] Target;
    logic [D-1:0] Prog_ctr;
    logic         Fetch_en, Done, Stack_err;

    int compared   = 0;
    int mismatched = 0;

    pc_sequencer #(.D(D)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Stall     (Stall),
        .Halt      (Halt),
        .Jump      (Jump),
        .Call      (Call),
        .Ret       (Ret),
        .Target    (Target),
        .Prog_ctr  (Prog_ctr),
        .Fetch_en  (Fetch_en),
        .Done      (Done),
        .Stack_err (Stack_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic h,
                         input logic j, input logic c, input logic r,
                         input int tgt);
        Start  = st;
        Stall  = sl;
        Halt   = h;
        Jump   = j;
        Call   = c;
        Ret    = r;
        Target = D'(tgt);
    endtask

    // Advance one edge, then settle before sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int pc, input int fe,
                             input int dn, input int err);
        chk({tag, ".pc"},  int'(Prog_ctr),  pc);
        chk({tag, ".fe"},  int'(Fetch_en),  fe);
        chk({tag, ".dn"},  int'(Done),      dn);
        chk({tag, ".err"}, int'(Stack_err), err);
    endtask

    int exp_err;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        #12;
        chk_state("reset", 0, 0, 0, 0);
        // Start ignored by nothing else in IDLE: other inputs must not matter
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(0, 0, 0, 1, 0, 0, 77);
        step();
        chk_state("idle_hold", 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk_state("start", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_state($sformatf("inc%0d", i), i, 1, 0, 0);
        end

        // Stall wins over Jump; then the Jump takes effect
        drive(0, 1, 0, 1, 0, 0, 81);
        step();
        chk("stall_jump.pc", int'(Prog_ctr), 5);
        drive(0, 0, 0, 1, 0, 0, 81);
        step();
        chk("jump.pc", int'(Prog_ctr), 81);

        // Start in RUN is ignored
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("start_in_run.pc", int'(Prog_ctr), 82);

        // Wrap 1023 -> 0
        drive(0, 0, 0, 1, 0, 0, 1023);
        step();
        chk("to1023.pc", int'(Prog_ctr), 1023);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk_state("wrap", 0, 1, 0, 0);

        // Halt beats all other controls
        drive(0, 0, 1, 1, 1, 1, 300);
        step();
        chk_state("halt_prio", 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk_state("restart0", 0, 1, 0, 0);

        // Call / Ret
        drive(0, 0, 0, 1, 0, 0, 10);
        step();
        drive(0, 0, 0, 0, 1, 0, 44);
        step();
        chk("call.pc", int'(Prog_ctr), 44);
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
`ifdef PC_RETSTACK_EN
        chk("ret.pc", int'(Prog_ctr), 11);
`else
        chk("ret.pc", int'(Prog_ctr), 45);
`endif
        chk("ret.err", int'(Stack_err), 0);

        // Five nested calls: fourth fills the stack, fifth overflows
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, i * 100);
            step();
            chk($sformatf("ncall%0d.pc", i), int'(Prog_ctr), i * 100);
`ifdef PC_RETSTACK_EN
            exp_err = (i == 5) ? 1 : 0;
`else
            exp_err = 0;
`endif
            chk($sformatf("ncall%0d.err", i), int'(Stack_err), exp_err);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
`ifdef PC_RETSTACK_EN
        chk("ret_full.pc", int'(Prog_ctr), 301);
`else
        chk("ret_full.pc", int'(Prog_ctr), 501);
`endif

        // Halt at 120, hold in DONE, restart keeps Stack_err
        drive(0, 0, 0, 1, 0, 0, 120);
        step();
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        chk_state("halt", 120, 0, 1, exp_err);
        drive(0, 0, 0, 1, 0, 0, 9);
        step();
        chk_state("done_hold", 120, 0, 1, exp_err);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk_state("restart", 0, 1, 0, exp_err);

        // Asynchronous reset mid-RUN, between edges
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("pre_rst.pc", int'(Prog_ctr), 2);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk_state("resume", 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("resume_inc.pc", int'(Prog_ctr), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
